stopwatch_ms_param: RTL and testbench
=====================================

Name: stopwatch_ms_param

Overview:
- Parametrised successor to the team's millisecond stopwatch: hh:mm:ss.mmm counter with an internal ms prescaler.
- Adds up/down (countdown) mode, synchronous clear and preset load, lap capture, hour wrap flag and a countdown-done pulse.
- Sits between the board clock and the 7-segment/display formatter. Outputs are binary fields; BCD conversion happens downstream.

Parameters:
- CLK_DIV, 100000: clk_i cycles per millisecond; must be >= 2 (use 4 in simulation).
- HOUR_MAX, 24: number of hour values; hours count 0..HOUR_MAX-1.
- HOUR_W, 5: width of hour fields; must satisfy 2^HOUR_W >= HOUR_MAX.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- run_i  in  1  level: 1 = counting, 0 = paused.
- mode_i  in  1  0 = count up, 1 = count down.
- clear_i  in  1  synchronous clear of time and lap registers.
- load_i  in  1  synchronous preset from the *_set_i inputs.
- hour_set_i  in  HOUR_W  preset hours.
- min_set_i  in  6  preset minutes.
- sec_set_i  in  6  preset seconds.
- lap_i  in  1  single-cycle pulse that captures the current time.
- ms_o  out  10  milliseconds, 0..999.
- sec_o  out  6  seconds, 0..59.
- min_o  out  6  minutes, 0..59.
- hour_o  out  HOUR_W  hours, 0..HOUR_MAX-1.
- lap_ms_o, lap_sec_o, lap_min_o, lap_hour_o  out  10/6/6/HOUR_W  captured lap time.
- lap_valid_o  out  1  lap registers hold a capture.
- wrap_o  out  1  one-cycle pulse on an up-count wrap from max to zero.
- done_o  out  1  one-cycle pulse when a countdown reaches zero.

Behaviour:
- Reset (reset_i=0, asynchronous): all time fields, lap fields, prescaler, lap_valid_o, wrap_o and done_o go to 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while run_i=1.
  - Holds its value while run_i=0, so a pause keeps the fractional millisecond.
  - tick = (run_i=1 && prescaler==CLK_DIV-1); the prescaler returns to 0 on the same edge.
- Per-edge priority: clear_i > load_i > tick.
  - clear_i zeroes the time fields, the prescaler, all lap fields and lap_valid_o.
  - load_i sets hour/min/sec from the preset inputs, sets ms to 0 and zeroes the prescaler. Lap fields are untouched.
  - Load clamping: sec and min values above 59 load as 59; hour values >= HOUR_MAX load as HOUR_MAX-1.
- Up count (mode_i=0), on each tick:
  - ms increments and wraps 999->0 with a carry into sec.
  - sec wraps 59->0 with a carry into min; min wraps 59->0 with a carry into hour.
  - hour wraps HOUR_MAX-1->0; this full rollover asserts wrap_o for one cycle.
  - All carries resolve within the same edge, so outputs are consistent every cycle.
- Down count (mode_i=1), on each tick:
  - ms decrements with borrows in the mirror image of the up count (0->999, 0->59, 0->59).
  - At 00:00:00.001 the tick moves the time to all-zero and done_o pulses for one cycle.
  - At all-zero, ticks leave the time unchanged, with no done_o and no wrap.
- mode_i may change at any time; it takes effect on the next tick, and the current value is kept.
- Lap capture:
  - lap_i=1 captures the time fields as they are before this edge's update into the lap registers and sets lap_valid_o.
  - A later lap_i overwrites the capture.
  - clear_i on the same edge wins: lap fields become 0 and lap_valid_o becomes 0.
- wrap_o and done_o are registered and forced to 0 on any edge where clear_i or load_i is asserted.
- Latency: outputs update on the clock edge of the tick, with no extra pipeline stage.

Test Plan:
- Reset mid-count: with CLK_DIV=4 and the counter running, assert reset_i=0 between edges -> all outputs read 0 immediately (asynchronous), and counting resumes after release.
- Up-count prescale and rollover: load 23:59:59, then run with mode_i=0 -> ms advances once every 4 clk_i; at 999 ms the next tick gives 00:00:00.000 with wrap_o high for exactly one cycle.
- Pause and resume: run for 10 clk_i, drop run_i for 20 cycles, raise it again -> no ms change while paused, and the next tick arrives after the remaining 2 cycles.
- Countdown done: load 00:00:01, set mode_i=1 -> ticks give 00:00:00.999 ... 00:00:00.000; done_o pulses once; further ticks hold at 0.
- Lap, clear and load interactions:
  - lap_i at 00:00:02.345 -> lap fields read 2/345 and lap_valid_o=1 while the counter continues.
  - clear_i together with lap_i -> everything reads 0.
  - load sec_set_i=63 -> sec_o reads 59.
- Clear/load priority: assert clear_i and load_i together on a tick edge -> all fields read 0 and the prescaler restarts at 0.

Source files
------------

// File: rtl/stopwatch_ms_param.sv
// stopwatch_ms_param: hh:mm:ss.mmm up/down stopwatch with ms prescaler,
// preset load, lap capture and one-cycle wrap/done pulses.
module stopwatch_ms_param #(
    parameter int CLK_DIV  = 100000,
    parameter int HOUR_MAX = 24,
    parameter int HOUR_W   = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic              mode_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [HOUR_W-1:0] hour_set_i,
    input  logic [5:0]        min_set_i,
    input  logic [5:0]        sec_set_i,
    input  logic              lap_i,
    output logic [9:0]        ms_o,
    output logic [5:0]        sec_o,
    output logic [5:0]        min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic [9:0]        lap_ms_o,
    output logic [5:0]        lap_sec_o,
    output logic [5:0]        lap_min_o,
    output logic [HOUR_W-1:0] lap_hour_o,
    output logic              lap_valid_o,
    output logic              wrap_o,
    output logic              done_o
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

    logic [PW-1:0]     pre_q, pre_d;
    logic [9:0]        ms_q, ms_d, lap_ms_q, lap_ms_d;
    logic [5:0]        sec_q, sec_d, min_q, min_d;
    logic [5:0]        lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
    logic [HOUR_W-1:0] hour_q, hour_d, lap_hour_q, lap_hour_d;
    logic              lap_valid_q, lap_valid_d, wrap_q, wrap_d, done_q, done_d;
    logic              tick, ms_c, sec_c, min_c, hour_c, ms_b, sec_b, min_b, zero;

    always_comb begin
        tick   = run_i && pre_q == PRE_LAST;
        ms_c   = ms_q == 10'd999;
        sec_c  = ms_c && sec_q == 6'd59;
        min_c  = sec_c && min_q == 6'd59;
        hour_c = min_c && hour_q == HOUR_LAST;
        ms_b   = ms_q == '0;
        sec_b  = ms_b && sec_q == '0;
        min_b  = sec_b && min_q == '0;
        zero   = min_b && hour_q == '0;
        pre_d  = tick ? '0 : pre_q + PW'(run_i);
        ms_d   = ms_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        wrap_d = 1'b0;
        done_d = 1'b0;
        // lap samples the pre-update time
        lap_ms_d    = lap_i ? ms_q : lap_ms_q;
        lap_sec_d   = lap_i ? sec_q : lap_sec_q;
        lap_min_d   = lap_i ? min_q : lap_min_q;
        lap_hour_d  = lap_i ? hour_q : lap_hour_q;
        lap_valid_d = lap_valid_q | lap_i;
        if (tick && !mode_i) begin
            ms_d   = ms_c ? '0 : ms_q + 10'd1;
            sec_d  = sec_c ? '0 : sec_q + 6'(ms_c);
            min_d  = min_c ? '0 : min_q + 6'(sec_c);
            hour_d = hour_c ? '0 : hour_q + HOUR_W'(min_c);
            wrap_d = hour_c;
        end else if (tick && !zero) begin
            ms_d   = ms_b ? 10'd999 : ms_q - 10'd1;
            sec_d  = sec_b ? 6'd59 : sec_q - 6'(ms_b);
            min_d  = min_b ? 6'd59 : min_q - 6'(sec_b);
            hour_d = hour_q - HOUR_W'(min_b);
            done_d = hour_q == '0 && min_q == '0 && sec_q == '0 && ms_q == 10'd1;
        end
        if (load_i) begin
            hour_d = hour_set_i > HOUR_LAST ? HOUR_LAST : hour_set_i;
            min_d  = min_set_i > 6'd59 ? 6'd59 : min_set_i;
            sec_d  = sec_set_i > 6'd59 ? 6'd59 : sec_set_i;
            ms_d   = '0;
            pre_d  = '0;
            wrap_d = 1'b0;
            done_d = 1'b0;
        end
        if (clear_i) begin
            {hour_d, min_d, sec_d, ms_d, pre_d} = '0;
            {lap_hour_d, lap_min_d, lap_sec_d, lap_ms_d, lap_valid_d} = '0;
            wrap_d = 1'b0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pre_q       <= '0;
            ms_q        <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            lap_ms_q    <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hour_q  <= '0;
            lap_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            ms_q        <= ms_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            lap_ms_q    <= lap_ms_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            lap_hour_q  <= lap_hour_d;
            lap_valid_q <= lap_valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
        end
    end

    assign ms_o        = ms_q;
    assign sec_o       = sec_q;
    assign min_o       = min_q;
    assign hour_o      = hour_q;
    assign lap_ms_o    = lap_ms_q;
    assign lap_sec_o   = lap_sec_q;
    assign lap_min_o   = lap_min_q;
    assign lap_hour_o  = lap_hour_q;
    assign lap_valid_o = lap_valid_q;
    assign wrap_o      = wrap_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_stopwatch_ms_param.sv
// tb_stopwatch_ms_param: checks the stopwatch against a model that keeps time
// as a single millisecond count, with directed scenarios then random stimulus.
module tb_stopwatch_ms_param;
    localparam int DIV = 4, HMAX = 24, HW = 5;
    localparam int TOTAL = HMAX * 3600000;

    logic clk_i = 0, reset_i = 0, run_i = 0, mode_i = 0, clear_i = 0, load_i = 0, lap_i = 0;
    logic [HW-1:0] hour_set_i = '0;
    logic [5:0] min_set_i = '0, sec_set_i = '0;
    logic [9:0] ms_o, lap_ms_o;
    logic [5:0] sec_o, min_o, lap_sec_o, lap_min_o;
    logic [HW-1:0] hour_o, lap_hour_o;
    logic lap_valid_o, wrap_o, done_o;

    stopwatch_ms_param #(.CLK_DIV(DIV), .HOUR_MAX(HMAX), .HOUR_W(HW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .run_i(run_i), .mode_i(mode_i),
        .clear_i(clear_i), .load_i(load_i), .hour_set_i(hour_set_i),
        .min_set_i(min_set_i), .sec_set_i(sec_set_i), .lap_i(lap_i),
        .ms_o(ms_o), .sec_o(sec_o), .min_o(min_o), .hour_o(hour_o),
        .lap_ms_o(lap_ms_o), .lap_sec_o(lap_sec_o), .lap_min_o(lap_min_o),
        .lap_hour_o(lap_hour_o), .lap_valid_o(lap_valid_o),
        .wrap_o(wrap_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0, total = 0;
    int t, p, lap_t;
    bit lap_v, wrap_m, done_m, tick_m, en = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int clampv(input int v, input int m);
        return v > m ? m : v;
    endfunction

    // model: time is one integer of milliseconds, fields derived by division
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            t = 0; p = 0; lap_t = 0; lap_v = 0; wrap_m = 0; done_m = 0;
        end else begin
            tick_m = run_i && p == DIV - 1;
            wrap_m = 0;
            done_m = 0;
            if (clear_i) begin
                t = 0; p = 0; lap_t = 0; lap_v = 0;
            end else begin
                if (lap_i) begin lap_t = t; lap_v = 1; end
                if (load_i) begin
                    t = (clampv(int'(hour_set_i), HMAX - 1) * 3600 + clampv(int'(min_set_i), 59) * 60
                         + clampv(int'(sec_set_i), 59)) * 1000;
                    p = 0;
                end else begin
                    if (run_i) p = tick_m ? 0 : p + 1;
                    if (tick_m && !mode_i) begin
                        t = (t + 1) % TOTAL;
                        wrap_m = t == 0;
                    end else if (tick_m && t > 0) begin
                        t = t - 1;
                        done_m = t == 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_i) if (en) begin
        chk("ms", int'(ms_o), t % 1000);
        chk("sec", int'(sec_o), (t / 1000) % 60);
        chk("min", int'(min_o), (t / 60000) % 60);
        chk("hour", int'(hour_o), t / 3600000);
        chk("lap_ms", int'(lap_ms_o), lap_t % 1000);
        chk("lap_sec", int'(lap_sec_o), (lap_t / 1000) % 60);
        chk("lap_min", int'(lap_min_o), (lap_t / 60000) % 60);
        chk("lap_hour", int'(lap_hour_o), lap_t / 3600000);
        chk("lap_valid", int'(lap_valid_o), int'(lap_v));
        chk("wrap", int'(wrap_o), int'(wrap_m));
        chk("done", int'(done_o), int'(done_m));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        hour_set_i = HW'(h); min_set_i = 6'(m); sec_set_i = 6'(s); load_i = 1;
        cyc(1);
        load_i = 0;
    endtask

    initial begin
        cyc(2);
        chk("rst_ms", int'(ms_o), 0);
        chk("rst_valid", int'(lap_valid_o), 0);
        reset_i = 1;
        en = 1;
        // up-count rollover from 23:59:59
        do_load(23, 59, 59);
        chk("load_hour", int'(hour_o), 23);
        run_i = 1;
        cyc(3999);
        chk("pre_wrap_ms", int'(ms_o), 999);
        cyc(1);
        chk("wrap_pulse", int'(wrap_o), 1);
        chk("wrap_hour", int'(hour_o), 0);
        chk("wrap_ms", int'(ms_o), 0);
        cyc(1);
        chk("wrap_drop", int'(wrap_o), 0);
        // pause keeps fractional ms
        run_i = 0; clear_i = 1;
        cyc(1);
        clear_i = 0; run_i = 1;
        cyc(10);
        chk("run10_ms", int'(ms_o), 2);
        run_i = 0;
        cyc(20);
        chk("paused_ms", int'(ms_o), 2);
        run_i = 1;
        cyc(1);
        chk("resume1_ms", int'(ms_o), 2);
        cyc(1);
        chk("resume2_ms", int'(ms_o), 3);
        // countdown to zero
        run_i = 0;
        do_load(0, 0, 1);
        mode_i = 1; run_i = 1;
        cyc(4);
        chk("down_ms", int'(ms_o), 999);
        chk("down_sec", int'(sec_o), 0);
        cyc(3992);
        chk("down_ms1", int'(ms_o), 1);
        cyc(4);
        chk("done_ms", int'(ms_o), 0);
        chk("done_pulse", int'(done_o), 1);
        cyc(1);
        chk("done_drop", int'(done_o), 0);
        cyc(12);
        chk("hold_ms", int'(ms_o), 0);
        // lap capture
        run_i = 0; mode_i = 0;
        do_load(0, 0, 2);
        run_i = 1;
        cyc(1380);
        chk("lap_pre_ms", int'(ms_o), 345);
        lap_i = 1;
        cyc(1);
        lap_i = 0;
        chk("lap_sec_lit", int'(lap_sec_o), 2);
        chk("lap_ms_lit", int'(lap_ms_o), 345);
        chk("lap_valid_lit", int'(lap_valid_o), 1);
        cyc(10);
        chk("lap_hold", int'(lap_ms_o), 345);
        chk("lap_run_ms", int'(ms_o), 347);
        // clear beats lap
        clear_i = 1; lap_i = 1;
        cyc(1);
        clear_i = 0; lap_i = 0;
        chk("clr_valid", int'(lap_valid_o), 0);
        chk("clr_lap_ms", int'(lap_ms_o), 0);
        chk("clr_ms", int'(ms_o), 0);
        // clamped load
        run_i = 0;
        do_load(31, 63, 63);
        chk("clamp_sec", int'(sec_o), 59);
        chk("clamp_min", int'(min_o), 59);
        chk("clamp_hour", int'(hour_o), 23);
        // clear + load on a tick edge
        run_i = 1;
        cyc(3);
        clear_i = 1; load_i = 1;
        cyc(1);
        clear_i = 0; load_i = 0;
        chk("cl_hour", int'(hour_o), 0);
        chk("cl_sec", int'(sec_o), 0);
        cyc(3);
        chk("cl_pre_ms", int'(ms_o), 0);
        cyc(1);
        chk("cl_tick_ms", int'(ms_o), 1);
        // asynchronous reset mid-count
        do_load(5, 6, 7);
        cyc(6);
        @(posedge clk_i);
        #2 reset_i = 0;
        #1;
        chk("arst_ms", int'(ms_o), 0);
        chk("arst_sec", int'(sec_o), 0);
        chk("arst_hour", int'(hour_o), 0);
        @(negedge clk_i);
        reset_i = 1;
        cyc(3);
        chk("arst_resume0", int'(ms_o), 0);
        cyc(1);
        chk("arst_resume1", int'(ms_o), 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            run_i = $urandom_range(0, 99) < 85;
            if ($urandom_range(0, 99) < 2) mode_i = ~mode_i;
            clear_i = $urandom_range(0, 199) == 0;
            load_i = $urandom_range(0, 99) < 2;
            lap_i = $urandom_range(0, 99) < 3;
            hour_set_i = HW'($urandom_range(0, 31));
            min_set_i = $urandom_range(0, 1) ? 6'($urandom_range(0, 63)) : 6'd0;
            sec_set_i = 6'($urandom_range(0, 63));
            cyc(1);
        end
        {run_i, clear_i, load_i, lap_i} = '0;
        cyc(2);
        en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
